// File: rtl/div_if.sv
// EX-stage to divider connection: operands and control from EX, result and ready back.
// start_i is held by EX until ready_o; result_o is valid while ready_o=1; dropping start_i releases it.
interface div_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result_o = {remainder, quotient}.
// One quotient bit per clock on magnitudes, signs applied on the final edge.
module div #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_if.slave       bus,
  output logic [1:0] state_dbg
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {FREE = 2'd0, BYZERO = 2'd1, ON = 2'd2, END = 2'd3} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dividend_raw;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             sgn_op;
  logic             neg2;

  logic             accept;
  logic             neg1;
  logic [WIDTH-1:0] dvd_mag;
  logic [IW-1:0]    bit_idx;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;
  logic             cnt_done;

  assign accept    = bus.start_i && !bus.annul_i;
  assign cnt_done  = (cnt == CW'(WIDTH));
  assign state_dbg = state;

  // Dividend magnitude is re-derived from the latched raw value; bits enter MSB first.
  assign neg1     = sgn_op && dividend_raw[WIDTH-1];
  assign dvd_mag  = neg1 ? (~dividend_raw + 1'b1) : dividend_raw;
  assign bit_idx  = IW'(WIDTH - 1) - cnt[IW-1:0];
  assign shifted  = {rem, dvd_mag[bit_idx]};
  assign diff     = shifted - {1'b0, dvs};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

  // Remainder follows the dividend sign; quotient is negated when the signs differ.
  assign quo_final = (neg1 ^ neg2) ? (~quo + 1'b1) : quo;
  assign rem_final = neg1 ? (~rem + 1'b1) : rem;

  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FREE: begin
        if (accept) state_next = (bus.opdata2_i == '0) ? BYZERO : ON;
      end
      BYZERO: state_next = END;
      ON: begin
        if (bus.annul_i)   state_next = FREE;
        else if (cnt_done) state_next = END;
      end
      END: begin
        if (!bus.start_i) state_next = FREE;
      end
      default: state_next = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      dividend_raw <= '0;
      dvs          <= '0;
      rem          <= '0;
      quo          <= '0;
      sgn_op       <= 1'b0;
      neg2         <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          bus.result_o <= '0;
          bus.ready_o  <= 1'b0;
          if (accept) begin
            sgn_op       <= bus.signed_div_i;
            neg2         <= bus.signed_div_i && bus.opdata2_i[WIDTH-1];
            dividend_raw <= bus.opdata1_i;
            dvs          <= (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ?
                            (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
            cnt          <= '0;
            rem          <= '0;
            quo          <= '0;
          end
        end
        BYZERO: begin
          bus.result_o <= '0;
        end
        ON: begin
          if (bus.annul_i) begin
            bus.result_o <= '0;
            bus.ready_o  <= 1'b0;
          end else if (!cnt_done) begin
            rem <= rem_next;
            quo <= {quo[WIDTH-2:0], q_bit};
            cnt <= cnt + 1'b1;
          end else begin
            bus.result_o <= {rem_final, quo_final};
            bus.ready_o  <= 1'b1;
          end
        end
        END: begin
          // The zero-divisor path arrives here with ready low; it rises on this edge.
          if (!bus.start_i) begin
            bus.result_o <= '0;
            bus.ready_o  <= 1'b0;
          end else begin
            bus.ready_o  <= 1'b1;
          end
        end
        default: begin
          bus.result_o <= '0;
          bus.ready_o  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: scoreboard of expected {remainder, quotient} values,
// latency, hold, release, annul and reset-abort scenarios.
module tb_div;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;

  div_if #(.WIDTH(W)) bus();

  div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic na, nb;
    logic [W-1:0] ma, mb, q, r;
    if (b == '0) return '0;
    na = sgn & a[W-1];
    nb = sgn & b[W-1];
    ma = na ? -a : a;
    mb = nb ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (na ^ nb) q = -q;
    if (na)      r = -r;
    return {r, q};
  endfunction

  task automatic start_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input bit push);
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    if (push) exp_q.push_back(exp);
  endtask

  // Counts edges from the accept edge until ready, then checks result, hold and release.
  task automatic wait_result(input string tag, input int lat);
    int edges;
    bit got;
    logic [2*W-1:0] e;
    edges = 0;
    got   = 1'b0;
    while (edges < 100 && !got) begin
      @(posedge clk);
      edges++;
      #1;
      if (bus.ready_o) got = 1'b1;
      if (edges == 1) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = ~bus.signed_div_i;
      end
    end
    check($sformatf("%s latency", tag), edges, lat);
    check($sformatf("%s queue", tag), exp_q.size(), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check($sformatf("%s result", tag), bus.result_o, e);
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("%s hold", tag), {state_dbg, bus.ready_o, bus.result_o}, {2'd3, 1'b1, e});
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check($sformatf("%s release", tag), {state_dbg, bus.ready_o, bus.result_o}, '0);
    @(negedge clk);
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] exp);
    start_op(sgn, a, b, exp, 1'b1);
    wait_result(tag, (b == '0) ? 3 : W + 2);
  endtask

  initial begin
    logic sgn;
    logic [W-1:0] a, b;
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {state_dbg, bus.ready_o, bus.result_o}, '0);
    @(negedge clk);
    rst = 1'b0;

    run_div("u100_7",   1'b0, 32'd100,        32'd7,          {32'd2,        32'd14});
    run_div("s_m7_2",   1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_div("u_m7_2",   1'b0, 32'hFFFFFFF9,   32'd2,          {32'h1,        32'h7FFFFFFC});
    run_div("s_min_m1", 1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0,        32'h80000000});
    run_div("s_7_m2",   1'b1, 32'd7,          32'hFFFFFFFE,   {32'h1,        32'hFFFFFFFD});
    run_div("zero",     1'b0, 32'd5,          32'd0,          64'd0);

    // Annul at cnt=10 (after the 11th edge from accept).
    start_op(1'b0, 32'd1000, 32'd7, '0, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    check("annul pre", state_dbg, 2'd2);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul", {state_dbg, bus.ready_o, bus.result_o}, '0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul idle", {state_dbg, bus.ready_o}, '0);
    run_div("u9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

    // Reset at cnt=20 with start held; the pending op is re-accepted after reset.
    start_op(1'b0, 32'd100000, 32'd13, {32'd4, 32'd7692}, 1'b1);
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst abort", {state_dbg, bus.ready_o, bus.result_o}, '0);
    @(negedge clk);
    rst = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100000;
    bus.opdata2_i    = 32'd13;
    wait_result("rst reaccept", W + 2);

    for (int i = 0; i < 6; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(1, 20));
        1:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_div($sformatf("rand%0d", i), sgn, a, b, model(sgn, a, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
